imm_stage: RTL and testbench
============================

# imm_stage

Registered, flow-controlled immediate generator for the decode stage of the pipelined core. It extracts and sign- or zero-extends the immediate from an instruction word to a parametrised XLEN and adds CSR zimm and shift-amount formats. It carries a sideband tag and flags malformed format selects. It sits between the fetch/decode boundary and the register-read stage, using a valid/ready handshake with a 2-entry skid buffer so backpressure never drops an instruction.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64
- TAG_W, 32, width of the opaque sideband tag carried alongside (e.g. PC)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  upstream word valid
- o_ready  out  1  stage can accept a word this cycle
- i_inst  in  32  instruction word
- i_format  in  8  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J, [6] Z (CSR zimm), [7] SH (shamt)
- i_tag  in  TAG_W  sideband, passed through unmodified
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts output this cycle
- o_immediate  out  XLEN  decoded immediate
- o_tag  out  TAG_W  tag of the current output word
- o_fmt_err  out  1  i_format had more than one bit set; immediate forced to 0

## Operation
- Decode is combinational on the input side, then registered. Sign bit is always i_inst[31], replicated to XLEN.
- I: sext(inst[31:20]).
- S: sext({inst[31:25], inst[11:7]}).
- B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- U: sext({inst[31:12], 12'b0}), with bit 31 extended for XLEN=64.
- J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- Z: zext(inst[19:15]). This format is never sign-extended.
- SH: zext(inst[24:20]) for XLEN=32; zext(inst[25:20]) for XLEN=64.
- R, or i_format == 0: immediate 0, o_fmt_err 0.
- More than one bit set in i_format: immediate 0, o_fmt_err 1. The word still flows normally and is not dropped.
- Storage is a main output register plus one skid register, each holding {imm, tag, err, valid}.
- An upstream transfer occurs when i_valid & o_ready. A downstream transfer occurs when o_valid & i_ready.
- o_ready = ~skid_valid, gated to 0 while i_rst_n is low.
- Main register loads when it is empty or being drained this cycle:
  - from skid, if skid_valid;
  - otherwise from the input.
- If the main register holds data that is not drained and an upstream transfer occurs, the new word goes into skid.
- Ordering is strictly FIFO. The output is never reordered or duplicated.

## Timing
- Latency: 1 cycle from an accepted input to o_valid.
- Throughput: 1 word/cycle while i_ready is held high.
- Reset values (while i_rst_n is low at a clock edge): o_valid 0, skid empty, o_immediate 0, o_tag 0, o_fmt_err 0. o_ready is 0 during reset and 1 in the first cycle after release.
- Output stability: while o_valid & ~i_ready, o_immediate, o_tag and o_fmt_err hold stable.
- Full condition: both main and skid registers valid. o_ready drops the cycle after the skid fills. Skid drains into main on the next downstream transfer, and o_ready returns high the following cycle.
- Simultaneous upstream and downstream transfer with an empty skid: main reloads from the input. No bubble, skid untouched.
- Reset mid-operation discards both held words. No partial state survives.

## Structure
- Shared package `imm_pkg`:
  - format index localparams (FMT_R … FMT_SH) and the format width of 8;
  - the legal XLEN set.
- One sub-module, `imm_decode`: the purely combinational extractor (i_inst, i_format → imm, err), parametrised by XLEN.
- `imm_stage` wraps `imm_decode` with the main/skid registers and handshake.
- Elaboration-time check: an XLEN other than 32 or 64 is a fatal error.

## Test plan
- XLEN=32, I-type 0xFFF00093, tag 0x1000, i_ready=1 → next cycle o_valid=1, o_immediate=0xFFFFFFFF, o_tag=0x1000.
- XLEN=32, B-type 0xFE000EE3 → 0xFFFFFFFC. J-type 0x0010006F → 0x00000800.
- XLEN=64:
  - U-type 0x800000B7 → 0xFFFFFFFF80000000;
  - SH 0x43F0D093 → 0x3F;
  - Z with inst[19:15]=5'b11111 and inst[31]=1 → 0x1F.
- Backpressure: stream 4 words with i_ready=0 from cycle 2.
  - o_ready falls after 2 words are held.
  - Release i_ready → all 4 words emerge in order, none lost or duplicated, outputs stable while stalled.
- i_format=8'b0000_0110 → o_immediate=0, o_fmt_err=1, word still delivered. Next word is R-type → 0 with o_fmt_err=0.
- Fill both registers, then assert i_rst_n=0 for one cycle → o_valid=0, o_ready=0 during reset, o_ready=1 next cycle, and no stale word appears.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generation stage.
package imm_pkg;

    // One-hot format select width and bit positions.
    localparam int unsigned FMT_W  = 8;
    localparam int unsigned FMT_R  = 0;
    localparam int unsigned FMT_I  = 1;
    localparam int unsigned FMT_S  = 2;
    localparam int unsigned FMT_B  = 3;
    localparam int unsigned FMT_U  = 4;
    localparam int unsigned FMT_J  = 5;
    localparam int unsigned FMT_Z  = 6;
    localparam int unsigned FMT_SH = 7;

    // Supported output widths.
    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: instruction word + one-hot format -> XLEN immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]      i_inst,
    input  logic [FMT_W-1:0] i_format,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_err
);

    logic        sgn;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        unused_opcode;

    assign sgn = i_inst[31];
    // Opcode bits carry no immediate information in any format.
    assign unused_opcode = ^i_inst[6:0];

    // Build 32-bit forms; signed formats are then sign-extended to XLEN by cast.
    always_comb begin
        imm_i = {{20{sgn}}, i_inst[31:20]};
        imm_s = {{20{sgn}}, i_inst[31:25], i_inst[11:7]};
        imm_b = {{19{sgn}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        imm_u = {i_inst[31:12], 12'b0};
        imm_j = {{11{sgn}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    end

    // Select by format; more than one bit set is flagged and yields zero.
    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        if ((i_format & (i_format - FMT_W'(1))) != '0) begin
            o_err = 1'b1;
        end else begin
            unique case (i_format)
                FMT_W'(1) << FMT_R:  o_imm = '0;
                FMT_W'(1) << FMT_I:  o_imm = XLEN'($signed(imm_i));
                FMT_W'(1) << FMT_S:  o_imm = XLEN'($signed(imm_s));
                FMT_W'(1) << FMT_B:  o_imm = XLEN'($signed(imm_b));
                FMT_W'(1) << FMT_U:  o_imm = XLEN'($signed(imm_u));
                FMT_W'(1) << FMT_J:  o_imm = XLEN'($signed(imm_j));
                FMT_W'(1) << FMT_Z:  o_imm = XLEN'(i_inst[19:15]);
                FMT_W'(1) << FMT_SH: o_imm = (XLEN == XLEN_64) ? XLEN'(i_inst[25:20])
                                                                : XLEN'(i_inst[24:20]);
                default:             o_imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/imm_stage.sv
// Registered immediate stage with valid/ready handshake and a one-entry skid buffer.
module imm_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [FMT_W-1:0] i_format,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_immediate,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_fmt_err
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $fatal(1, "imm_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic             main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic             up_xfer, main_load;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .i_inst  (i_inst),
        .i_format(i_format),
        .o_imm   (dec_imm),
        .o_err   (dec_err)
    );

    assign o_ready     = ~skid_valid_q & i_rst_n;
    assign o_valid     = main_valid_q;
    assign o_immediate = main_imm_q;
    assign o_tag       = main_tag_q;
    assign o_fmt_err   = main_err_q;

    // Next state: main refills from skid first (FIFO order), otherwise from the input.
    always_comb begin
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        main_valid_d = main_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;

        up_xfer   = i_valid & o_ready;
        main_load = ~main_valid_q | i_ready;

        if (main_load) begin
            if (skid_valid_q) begin
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                main_err_d   = skid_err_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = up_xfer;
                if (up_xfer) begin
                    main_imm_d = dec_imm;
                    main_tag_d = i_tag;
                    main_err_d = dec_err;
                end
            end
        end else if (up_xfer) begin
            skid_imm_d   = dec_imm;
            skid_tag_d   = i_tag;
            skid_err_d   = dec_err;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset clearing both entries.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            main_valid_q <= main_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: tb/tb_imm_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances driven by the same stimulus.
module tb_imm_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [7:0]  fmt;
    logic [31:0] tag;

    logic        rdy32, val32, err32;
    logic [31:0] imm32, tag32;
    logic        rdy64, val64, err64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy32),
        .i_inst(inst), .i_format(fmt), .i_tag(tag), .o_valid(val32),
        .i_ready(out_ready), .o_immediate(imm32), .o_tag(tag32), .o_fmt_err(err32)
    );

    imm_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy64),
        .i_inst(inst), .i_format(fmt), .i_tag(tag), .o_valid(val64),
        .i_ready(out_ready), .o_immediate(imm64), .o_tag(tag64), .o_fmt_err(err64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  fmt;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 8'h02, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // I
        vecs[1]  = '{32'hFE000EE3, 8'h08, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // B
        vecs[2]  = '{32'h0010006F, 8'h20, 32'h00000800, 64'h0000000000000800, 1'b0}; // J
        vecs[3]  = '{32'h800000B7, 8'h10, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0}; // U
        vecs[4]  = '{32'h43F0D093, 8'h80, 32'h0000001F, 64'h000000000000003F, 1'b0}; // SH
        vecs[5]  = '{32'h800F8073, 8'h40, 32'h0000001F, 64'h000000000000001F, 1'b0}; // Z
        vecs[6]  = '{32'h80000F80, 8'h04, 32'hFFFFF81F, 64'hFFFFFFFFFFFFF81F, 1'b0}; // S
        vecs[7]  = '{32'hFFF00093, 8'h06, 32'h00000000, 64'h0000000000000000, 1'b1}; // I|S
        vecs[8]  = '{32'hFFFFFFFF, 8'h01, 32'h00000000, 64'h0000000000000000, 1'b0}; // R
        vecs[9]  = '{32'hFFFFFFFF, 8'h00, 32'h00000000, 64'h0000000000000000, 1'b0}; // none
        vecs[10] = '{32'h7FF00013, 8'h02, 32'h000007FF, 64'h00000000000007FF, 1'b0}; // I pos
        vecs[11] = '{32'h02000013, 8'h80, 32'h00000000, 64'h0000000000000020, 1'b0}; // SH b25
        vecs[12] = '{32'hFFFFFFFF, 8'h81, 32'h00000000, 64'h0000000000000000, 1'b1}; // R|SH

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; fmt = '0; tag = '0;
        step();
        step();
        chk("rst_o_valid", {63'b0, val32}, 64'd0);
        chk("rst_o_ready", {63'b0, rdy32}, 64'd0);
        chk("rst_o_ready64", {63'b0, rdy64}, 64'd0);
        chk("rst_o_imm", {32'b0, imm32}, 64'd0);
        chk("rst_o_tag", {32'b0, tag32}, 64'd0);
        chk("rst_o_err", {63'b0, err32}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {63'b0, rdy32}, 64'd1);

        // Back-to-back table vectors at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            inst = vecs[i].inst; fmt = vecs[i].fmt; tag = 32'h1000 + i; in_valid = 1'b1;
            step();
            chk($sformatf("v%0d_valid", i), {62'b0, val64, val32}, 64'd3);
            chk($sformatf("v%0d_imm32", i), {32'b0, imm32}, {32'b0, vecs[i].e32});
            chk($sformatf("v%0d_imm64", i), imm64, vecs[i].e64);
            chk($sformatf("v%0d_err", i), {62'b0, err64, err32}, {62'b0, vecs[i].err, vecs[i].err});
            chk($sformatf("v%0d_tag", i), {tag64, tag32}, {32'h1000 + i, 32'h1000 + i});
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'b0, val32}, 64'd0);

        // Backpressure: 4 words, i_ready dropped after the first is accepted.
        fmt = 8'h02;
        inst = (32'd1 << 20) | 32'h13; tag = 32'hA0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        inst = (32'd2 << 20) | 32'h13; tag = 32'hA1;
        step();
        chk("bp_full_ready", {63'b0, rdy32}, 64'd0);
        chk("bp_w0_tag", {32'b0, tag32}, 64'hA0);
        inst = (32'd3 << 20) | 32'h13; tag = 32'hA2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_stall%0d_valid", k), {63'b0, val32}, 64'd1);
            chk($sformatf("bp_stall%0d_tag", k), {32'b0, tag32}, 64'hA0);
            chk($sformatf("bp_stall%0d_imm", k), {32'b0, imm32}, 64'd1);
            chk($sformatf("bp_stall%0d_ready", k), {63'b0, rdy32}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_w1_tag", {32'b0, tag32}, 64'hA1);
        chk("bp_w1_imm", {32'b0, imm32}, 64'd2);
        chk("bp_ready_back", {63'b0, rdy32}, 64'd1);
        step();
        chk("bp_w2_tag", {32'b0, tag32}, 64'hA2);
        chk("bp_w2_imm", {32'b0, imm32}, 64'd3);
        inst = (32'd4 << 20) | 32'h13; tag = 32'hA3;
        step();
        chk("bp_w3_tag", {32'b0, tag32}, 64'hA3);
        chk("bp_w3_imm", {32'b0, imm32}, 64'd4);
        in_valid = 1'b0;
        step();
        chk("bp_end_valid", {63'b0, val32}, 64'd0);

        // Fill main and skid, then reset for one cycle.
        out_ready = 1'b0; in_valid = 1'b1; tag = 32'hB0;
        step();
        tag = 32'hB1;
        step();
        chk("fill_ready", {63'b0, rdy32}, 64'd0);
        chk("fill_valid", {63'b0, val32}, 64'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_ready_comb", {63'b0, rdy32}, 64'd0);
        step();
        chk("rst_mid_valid", {62'b0, val64, val32}, 64'd0);
        chk("rst_mid_ready", {63'b0, rdy32}, 64'd0);
        chk("rst_mid_tag", {32'b0, tag32}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", {62'b0, rdy64, rdy32}, 64'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("no_stale%0d", k), {62'b0, val64, val32}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
